// File: rtl/adc_uart_streamer_if.sv
// ============================================================================
// Module   : adc_uart_streamer_if
// Brief    : ADC handshake, UART byte handshake and status bundle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_uart_streamer_if #(
  parameter int FIFO_AW = 4
);
  logic               enable;
  logic [9:0]         adc_data;
  logic               adc_available;
  logic               adc_clear_available;
  logic               uart_tx_start;
  logic [7:0]         uart_tx_data;
  logic               uart_tx_finish;
  logic [FIFO_AW:0]   fifo_level;
  logic [7:0]         overflow_count;

  modport master (
    output enable, adc_data, adc_available, uart_tx_finish,
    input  adc_clear_available, uart_tx_start, uart_tx_data, fifo_level, overflow_count
  );

  modport slave (
    input  enable, adc_data, adc_available, uart_tx_finish,
    output adc_clear_available, uart_tx_start, uart_tx_data, fifo_level, overflow_count
  );
endinterface

`default_nettype wire

// File: rtl/adc_uart_streamer.sv
// ============================================================================
// Module   : adc_uart_streamer
// Brief    : Buffers 10-bit ADC samples and sends each as a framed byte pair
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_uart_streamer #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  adc_uart_streamer_if.slave    io_bus
);

  localparam logic [0:0] c_CAP_IDLE = 1'b0;
  localparam logic [0:0] c_CAP_WAIT = 1'b1;

  localparam logic [2:0] c_TX_IDLE  = 3'd0;
  localparam logic [2:0] c_HI_START = 3'd1;
  localparam logic [2:0] c_HI_WAIT  = 3'd2;
  localparam logic [2:0] c_LO_START = 3'd3;
  localparam logic [2:0] c_LO_WAIT  = 3'd4;

  localparam logic [FIFO_AW:0] c_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [0:0]         r_cap_state, w_cap_next;
  logic [2:0]         r_tx_state, w_tx_next;
  logic               w_cap_fire, w_full, w_push, w_pop;
  logic               w_start;
  logic [7:0]         w_data;
  logic               r_clear;
  logic [7:0]         r_ovf;
  logic [9:0]         r_hold;
  logic [9:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_level;

  // ---------------- capture FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_cap_state <= c_CAP_IDLE;
    else     r_cap_state <= w_cap_next;
  end

  always_comb begin
    w_cap_next = r_cap_state;
    case (r_cap_state)
      c_CAP_IDLE: if (io_bus.enable && io_bus.adc_available) w_cap_next = c_CAP_WAIT;
      c_CAP_WAIT: if (!io_bus.adc_available)                  w_cap_next = c_CAP_IDLE;
      default:    w_cap_next = c_CAP_IDLE;
    endcase
  end

  always_comb begin
    w_cap_fire = (r_cap_state == c_CAP_IDLE) && io_bus.enable && io_bus.adc_available;
  end

  // Fullness uses the pre-edge level, so a same-cycle pop never rescues a push.
  assign w_full = (r_level == c_FULL);
  assign w_push = w_cap_fire && !w_full;
  assign w_pop  = (r_tx_state == c_TX_IDLE) && io_bus.enable && (r_level != '0);

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= c_TX_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      c_TX_IDLE:  if (w_pop)                 w_tx_next = c_HI_START;
      c_HI_START:                            w_tx_next = c_HI_WAIT;
      c_HI_WAIT:  if (io_bus.uart_tx_finish) w_tx_next = c_LO_START;
      c_LO_START:                            w_tx_next = c_LO_WAIT;
      c_LO_WAIT:  if (io_bus.uart_tx_finish) w_tx_next = c_TX_IDLE;
      default:                               w_tx_next = c_TX_IDLE;
    endcase
  end

  // Bit 7 tags high vs low byte so the host can resynchronise.
  always_comb begin
    w_start = 1'b0;
    w_data  = 8'h00;
    case (r_tx_state)
      c_HI_START: begin w_start = 1'b1; w_data = {1'b1, 4'b0000, r_hold[9:7]}; end
      c_HI_WAIT:  w_data = {1'b1, 4'b0000, r_hold[9:7]};
      c_LO_START: begin w_start = 1'b1; w_data = {1'b0, r_hold[6:0]}; end
      c_LO_WAIT:  w_data = {1'b0, r_hold[6:0]};
      default: begin
        w_start = 1'b0;
        w_data  = 8'h00;
      end
    endcase
  end

  // ---------------- FIFO and status ----------------
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= io_bus.adc_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clear <= 1'b0;
      r_ovf   <= 8'h00;
      r_hold  <= 10'h000;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      r_clear <= w_cap_fire;
      if (w_cap_fire && w_full && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
      if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + FIFO_AW'(1);
        r_hold <= r_mem[r_rptr];
      end
      r_level <= r_level + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};
    end
  end

  assign io_bus.adc_clear_available = r_clear;
  assign io_bus.uart_tx_start       = w_start;
  assign io_bus.uart_tx_data        = w_data;
  assign io_bus.fifo_level          = r_level;
  assign io_bus.overflow_count      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_adc_uart_streamer.sv
// ============================================================================
// Module   : tb_adc_uart_streamer
// Brief    : Randomised self-checking bench with a byte-stream reference model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_uart_streamer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_uart_streamer_if #(.FIFO_AW(AW)) bus ();

  adc_uart_streamer #(.FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_start = 0;
  int         n_clr = 0;
  int         n_unstable = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       tx_hold = 1'b0;
  logic       rst_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // A sample becomes a high byte carrying bits 9..7 under a set bit 7, then a low byte of bits 6..0.
  function automatic void expect_sample(input logic [9:0] s);
    exp_q.push_back(8'h80 + 8'(s / 128));
    exp_q.push_back(8'(s % 128));
  endfunction

  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) if (bus.adc_clear_available) n_clr++;

  // Transmitter: finish 10 cycles after each start unless held.
  initial begin : tx_model
    int         cnt;
    logic       busy;
    logic [7:0] cur;
    cnt = 0; busy = 1'b0; cur = 8'h00;
    bus.uart_tx_finish = 1'b0;
    forever begin
      @(negedge clk);
      bus.uart_tx_finish = 1'b0;
      if (rst_seen) begin
        busy = 1'b0;
      end else if (bus.uart_tx_start) begin
        busy = 1'b1; cnt = 0; cur = bus.uart_tx_data;
        got_q.push_back(cur);
        n_start++;
      end else if (busy && !tx_hold) begin
        cnt++;
        if (cnt >= 10) begin
          if (bus.uart_tx_data !== cur) n_unstable++;
          bus.uart_tx_finish = 1'b1;
          busy = 1'b0;
        end
      end
    end
  end

  task automatic send_sample(input logic [9:0] s);
    logic seen;
    seen = 1'b0;
    bus.adc_data = s;
    bus.adc_available = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.adc_clear_available;
    end
    chk("clear_seen", 32'(seen), 32'd1);
    bus.adc_available = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && got_q.size() < exp_q.size(); i++) @(negedge clk);
    repeat (15) @(negedge clk);
    chk({tag, "_bytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    chk({tag, "_level"}, 32'(bus.fifo_level), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [9:0] s;
    logic [9:0] dir[3];
    logic [9:0] q6[4];
    int c0, cs, nsamp;

    bus.enable = 1'b0;
    bus.adc_data = 10'h000;
    bus.adc_available = 1'b0;
    dir[0] = 10'h000; dir[1] = 10'h3FF; dir[2] = 10'h155;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(bus.uart_tx_start), 0);
    chk("rst_data",  32'(bus.uart_tx_data), 0);
    chk("rst_clear", 32'(bus.adc_clear_available), 0);
    chk("rst_level", 32'(bus.fifo_level), 0);
    chk("rst_ovf",   32'(bus.overflow_count), 0);
    rst = 1'b0;
    bus.enable = 1'b1;
    @(negedge clk);

    // single sample with cycle-exact latency
    c0 = n_clr;
    bus.adc_data = 10'h2C5;
    bus.adc_available = 1'b1;
    @(negedge clk);
    chk("lat_clear",  32'(bus.adc_clear_available), 1);
    chk("lat_level1", 32'(bus.fifo_level), 1);
    chk("lat_nostart", 32'(bus.uart_tx_start), 0);
    bus.adc_available = 1'b0;
    @(negedge clk);
    chk("lat_start",  32'(bus.uart_tx_start), 1);
    chk("lat_hi",     32'(bus.uart_tx_data), 32'h85);
    chk("lat_level0", 32'(bus.fifo_level), 0);
    chk("lat_clear0", 32'(bus.adc_clear_available), 0);
    expect_sample(10'h2C5);
    wait_drain("single");
    chk("single_nclr", 32'(n_clr - c0), 1);

    // directed extremes then random samples with random gaps
    c0 = n_clr;
    for (int i = 0; i < 3; i++) begin
      send_sample(dir[i]);
      expect_sample(dir[i]);
    end
    for (int i = 0; i < 6; i++) begin
      s = 10'($urandom);
      send_sample(s);
      expect_sample(s);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain("burst");
    chk("burst_nclr", 32'(n_clr - c0), 9);

    // long-held available: exactly one capture until it drops
    c0 = n_clr;
    s = 10'($urandom);
    bus.adc_data = s;
    bus.adc_available = 1'b1;
    repeat (50) @(negedge clk);
    bus.adc_available = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_nclr1", 32'(n_clr - c0), 1);
    expect_sample(s);
    s = 10'($urandom);
    send_sample(s);
    expect_sample(s);
    chk("hold_nclr2", 32'(n_clr - c0), 2);
    wait_drain("hold");

    // transmitter stalled: 1 in flight + DEPTH buffered, the rest counted as overflow
    nsamp = $urandom_range(18, 20);
    tx_hold = 1'b1;
    cs = n_start;
    for (int i = 0; i < nsamp; i++) begin
      s = 10'($urandom);
      send_sample(s);
      if (i < DEPTH + 1) expect_sample(s);
    end
    repeat (3) @(negedge clk);
    chk("ovf_level", 32'(bus.fifo_level), DEPTH);
    chk("ovf_count", 32'(bus.overflow_count), 32'(nsamp - DEPTH - 1));
    chk("ovf_starts", 32'(n_start - cs), 1);
    tx_hold = 1'b0;
    wait_drain("ovf");

    // enable dropped in HI_WAIT: frame completes, queue retained
    tx_hold = 1'b1;
    cs = n_start;
    for (int i = 0; i < 4; i++) begin
      q6[i] = 10'($urandom);
      send_sample(q6[i]);
    end
    chk("en_level_q", 32'(bus.fifo_level), 3);
    expect_sample(q6[0]);
    bus.enable = 1'b0;
    c0 = n_clr;
    bus.adc_data = 10'($urandom);
    bus.adc_available = 1'b1;
    repeat (5) @(negedge clk);
    bus.adc_available = 1'b0;
    chk("en_noclear", 32'(n_clr - c0), 0);
    tx_hold = 1'b0;
    repeat (60) @(negedge clk);
    chk("en_starts", 32'(n_start - cs), 2);
    chk("en_level",  32'(bus.fifo_level), 3);
    chk("en_idle",   32'(bus.uart_tx_start), 0);
    bus.enable = 1'b1;
    for (int i = 1; i < 4; i++) expect_sample(q6[i]);
    wait_drain("enable");

    // reset during LO_WAIT with samples queued
    tx_hold = 1'b1;
    cs = n_start;
    s = 10'($urandom);
    send_sample(s);
    expect_sample(s);
    for (int i = 0; i < 5; i++) send_sample(10'($urandom));
    chk("rs_level_q", 32'(bus.fifo_level), 5);
    tx_hold = 1'b0;
    for (int i = 0; i < 200 && n_start < cs + 2; i++) @(negedge clk);
    tx_hold = 1'b1;
    chk("rs_lo_started", 32'(n_start - cs), 2);
    chk("rs_ovf_pre", 32'(bus.overflow_count), 32'(nsamp - DEPTH - 1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rs_start", 32'(bus.uart_tx_start), 0);
    chk("rs_data",  32'(bus.uart_tx_data), 0);
    chk("rs_clear", 32'(bus.adc_clear_available), 0);
    chk("rs_level", 32'(bus.fifo_level), 0);
    chk("rs_ovf",   32'(bus.overflow_count), 0);
    tx_hold = 1'b0;
    cs = n_start;
    repeat (40) @(negedge clk);
    chk("rs_silent", 32'(n_start - cs), 0);
    s = 10'($urandom);
    send_sample(s);
    expect_sample(s);
    wait_drain("post_rst");

    // full byte stream against the reference
    chk("stream_len", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    chk("tx_stable", 32'(n_unstable), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/adc_uart_streamer.md
# adc_uart_streamer

Streams MCP3002 conversion results to the host over UART. The block sits between the `mcp3002` controller and `uart_tx`. It acknowledges each ADC sample through the available/clear handshake and buffers samples in a small FIFO. Each 10-bit sample is serialised as two self-synchronising bytes, with byte starts paced by `uart_tx_finish`.

## Interface
- `FIFO_DEPTH`, 16: sample FIFO depth; power of two, 2..256.
- `FIFO_AW`, 4: log2(`FIFO_DEPTH`).

- `clk` input 1: system clock (27 MHz).
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: capture/stream enable.
- `adc_data` input 10: sample from the ADC controller, valid while `adc_available`=1.
- `adc_available` input 1: ADC has an unread sample.
- `adc_clear_available` output 1: one-cycle pulse acknowledging the sample.
- `uart_tx_start` output 1: one-cycle pulse that starts one UART byte.
- `uart_tx_data` output 8: byte to send; stable from the start pulse until the finish pulse.
- `uart_tx_finish` input 1: one-cycle pulse from the transmitter at the end of the stop bit.
- `fifo_level` output FIFO_AW+1: number of samples held, 0..FIFO_DEPTH.
- `overflow_count` output 8: count of dropped samples; saturates at 255.

## Operation
- Reset values: all outputs 0. FIFO empty. Both FSMs in their idle state.
- Capture FSM has two states, CAP_IDLE and CAP_WAIT.
  - CAP_IDLE, with `enable`=1 and `adc_available`=1:
    - If the FIFO is not full, write `adc_data`.
    - If the FIFO is full, drop the sample and increment `overflow_count` (saturating).
    - In both cases, pulse `adc_clear_available` next cycle and go to CAP_WAIT.
  - CAP_WAIT: ignore `adc_available` until it is sampled 0, then return to CAP_IDLE. A sample is never captured twice.
  - `enable`=0 in CAP_IDLE: no capture and no clear.
- TX FSM has five states: TX_IDLE → HI_START → HI_WAIT → LO_START → LO_WAIT → TX_IDLE.
  - TX_IDLE: if `enable`=1 and the FIFO is not empty, pop one sample into a holding register and go to HI_START.
  - HI_START: `uart_tx_start`=1 for one cycle, `uart_tx_data` = {1'b1, 4'b0000, s[9:7]}. Go to HI_WAIT.
  - HI_WAIT: hold `uart_tx_data`; advance to LO_START on `uart_tx_finish`.
  - LO_START: `uart_tx_start`=1 for one cycle, `uart_tx_data` = {1'b0, s[6:0]}. Go to LO_WAIT.
  - LO_WAIT: on `uart_tx_finish`, return to TX_IDLE.
- Framing rule: bit 7 = 1 marks the high byte and bit 7 = 0 marks the low byte, so the host resynchronises after a lost byte.
- `enable` falling mid-sample: the current two-byte frame always completes. No further pops occur. FIFO contents are retained.
- `uart_tx_finish` arriving in TX_IDLE, HI_START or LO_START is ignored.
- Simultaneous push and pop: both take effect and `fifo_level` is unchanged.
- Push while full: the sample is dropped even if a pop occurs in the same cycle. Fullness is judged from the pre-edge level.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by `fifo_level`.
- Reset mid-frame: returns to idle next edge, flushes the FIFO, clears `overflow_count`, and drops `uart_tx_start` and `uart_tx_data` to 0. The partial frame is abandoned.

## Timing
- Edge N: `adc_available` is first sampled 1 in CAP_IDLE; the FIFO write occurs at this edge.
- Cycle N+1: `adc_clear_available`=1 for this cycle only, and `fifo_level` reflects the write.
- With the FIFO empty and TX idle, the pop occurs at edge N+1 and `uart_tx_start` is high during cycle N+2. Latency from sample to start pulse is 2 cycles.
- `uart_tx_finish` at edge M produces the next `uart_tx_start` (low byte) during cycle M+1. The earliest next-sample high byte is at M+2 after the low-byte finish.
- Steady-state throughput: one sample per 20 UART bit times (about 480 samples/s at 9600 bps). The ADC rate above that is absorbed by the FIFO, then counted as overflow.

## Test plan
- Single sample 0x2C5 with an ideal transmitter model (finish 10 cycles after start) → bytes 0x85 then 0x45. One `adc_clear_available` pulse, two start pulses, `fifo_level` returns to 0.
- Samples 0x000, 0x3FF, 0x155 back-to-back → byte stream 0x80 0x00 0x87 0x7F 0x82 0x55 in order. No extra clears.
- Hold `adc_available`=1 for 50 cycles → exactly one capture and one clear. Drop it, raise it again → a second capture.
- Hold `uart_tx_finish`=0 and present 18 samples → 17 accepted (1 in TX, 16 in FIFO), `fifo_level`=16, `overflow_count`=1. Then release finish → the 17 samples appear in FIFO order.
- Deassert `enable` during HI_WAIT with 3 samples queued → the current low byte is still sent, then no start pulses and `fifo_level`=3. Reassert → streaming resumes.
- Assert `rst` for 1 cycle during LO_WAIT with 5 queued → all outputs 0 next cycle, `fifo_level`=0, `overflow_count`=0. Nothing is sent after reset until a new sample arrives.
